rgb_mixer_n: RTL and testbench
==============================

// Module: rgb_mixer_n
// PURPOSE
//   N-channel successor of the three-channel mixer: each channel debounces one quadrature encoder,
//   counts its detents into a WIDTH-bit level, and drives one PWM output at that duty.
//   Single clock domain: the divided clock is replaced by a one-cycle prescaler tick enable.
//   Adds selectable saturation, glitch-free duty updates and a flattened level readback bus.
// PARAMETERS
//   CHANNELS  3  number of encoder/PWM channels (1..16)
//   WIDTH     8  level/PWM counter width; PWM period = 2^WIDTH ticks
//   DIV_BITS  8  prescaler width; tick period = 2^DIV_BITS clk12MHz cycles
//   HIST_LEN  8  debounce history depth in ticks (>=2)
//   SATURATE  1  1: level clamps at 0 and 2^WIDTH-1; 0: level wraps modulo 2^WIDTH
// PORTS
//   clk12MHz   in   1               system clock; all flops on posedge
//   reset      in   1               asynchronous, active-high; clears all state
//   enc_a      in   CHANNELS        encoder A phase, bit i = channel i, asynchronous to clock
//   enc_b      in   CHANNELS        encoder B phase, bit i = channel i, asynchronous to clock
//   pwm_out    out  CHANNELS        PWM output, bit i = channel i, registered
//   level_out  out  CHANNELS*WIDTH  current encoder level, channel i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//   Reset: prescaler, synchronisers, histories, debounced bits, levels, PWM counter, latched
//     duties = 0; pwm_out = 0; level_out = 0. Asserting reset mid-operation clears immediately.
//   Prescaler: DIV_BITS counter increments every cycle and wraps; tick = 1 for exactly one
//     cycle when counter == all ones (first tick 2^DIV_BITS cycles after reset release).
//   Sync: enc_a/enc_b pass a 2-flop synchroniser every cycle (not tick-gated).
//   Debounce (per phase): on tick, shift synchronised bit into HIST_LEN history; debounced
//     bit <= 1 when history all ones, <= 0 when all zeros, else holds. Updates only on tick.
//   Encoder (per channel, x1 decode): on tick, a_prev <= a_db. Rising edge of a_db
//     (a_db=1, a_prev=0): b_db=0 -> level+1; b_db=1 -> level-1. No edge -> hold.
//     SATURATE=1: +1 at 2^WIDTH-1 and -1 at 0 are ignored. SATURATE=0: wraps (255+1=0, 0-1=255).
//     Only one step per channel per tick; channels are fully independent.
//   level_out reflects the level register directly (same cycle as update).
//   PWM: one shared WIDTH-bit counter advances on tick, wrapping 2^WIDTH-1 -> 0.
//     Each channel latches duty <= level on the tick where counter wraps to 0 (period start);
//     level changes mid-period never alter the current period.
//     pwm_out[i] registered = (counter < duty[i]); duty 0 -> constant 0; duty 2^WIDTH-1 ->
//     high 2^WIDTH-1 of 2^WIDTH ticks. pwm_out changes only in the cycle after a tick.
//   Latency: clean A edge -> level change = 2 sync cycles + HIST_LEN ticks (+1 tick for edge
//     detect, up to 1 tick alignment); level change -> pwm_out at next period start.
//   No combinational path from any input to any output.
// TESTING
//   1 Reset: hold reset, toggle all inputs -> pwm_out=0, level_out=0; release -> stay 0 until
//     first encoder step.
//   2 Step up/down (DIV_BITS=2, HIST_LEN=4): 5 clean A rises with B=0 -> level 5; then 2 with
//     B=1 -> level 3; pwm_out high 3 of every 256 ticks after next period start.
//   3 Bounce: A toggles every cycle for 3 ticks then settles high, B=0 -> exactly one increment.
//   4 Saturation: SATURATE=1, 260 up-steps -> level 255, one down -> 254; SATURATE=0 from 255
//     one up -> 0, from 0 one down -> 255.
//   5 Glitch-free update: change level from 10 to 200 mid-period -> current period shows 10
//     high ticks, next period 200; channel 1 steps never disturb channels 0/2.
//   6 Async reset mid-period with levels 7/100/255 -> all outputs 0 within the reset cycle,
//     no clock edge needed.

Source files
------------

// File: rtl/rgb_mixer_n.sv
// rgb_mixer_n: N-channel quadrature encoder to PWM mixer.
// Each channel debounces one encoder, counts detents into a level, drives a PWM.
//
// Ports:
//   clk12MHz  - system clock, all flops on posedge
//   reset     - asynchronous active-high reset, clears all state
//   enc_a     - encoder A phase per channel (asynchronous)
//   enc_b     - encoder B phase per channel (asynchronous)
//   pwm_out   - registered PWM output per channel
//   level_out - flattened level bus, channel i at [i*WIDTH +: WIDTH]
module rgb_mixer_n #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 8,
    parameter int HIST_LEN = 8,
    parameter int SATURATE = 1
) (
    input  logic                      clk12MHz,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] level_out
);

    localparam bit LP_WRAP = (SATURATE == 0);

    logic [DIV_BITS-1:0] r_div;
    logic                w_tick;

    // Free-running prescaler; tick is the single all-ones cycle.
    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = &r_div;

    logic [CHANNELS-1:0] r_a_meta;
    logic [CHANNELS-1:0] r_a_sync;
    logic [CHANNELS-1:0] r_b_meta;
    logic [CHANNELS-1:0] r_b_sync;

    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            r_a_meta <= '0;
            r_a_sync <= '0;
            r_b_meta <= '0;
            r_b_sync <= '0;
        end else begin
            r_a_meta <= enc_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= enc_b;
            r_b_sync <= r_b_meta;
        end
    end

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap;

    assign w_cnt_nxt = r_cnt + 1'b1;
    // Period start: the tick on which the counter rolls over to zero.
    assign w_wrap    = w_tick && (r_cnt == {WIDTH{1'b1}});

    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [HIST_LEN-1:0] r_a_hist;
        logic [HIST_LEN-1:0] r_b_hist;
        logic [HIST_LEN-1:0] w_a_hist;
        logic [HIST_LEN-1:0] w_b_hist;
        logic                r_a_db;
        logic                r_b_db;
        logic                r_a_prev;
        logic                w_rise;
        logic                w_up_ok;
        logic                w_dn_ok;
        logic [WIDTH-1:0]    r_level;
        logic [WIDTH-1:0]    r_duty;
        logic [WIDTH-1:0]    w_duty_nxt;
        logic                r_pwm;

        assign w_a_hist = {r_a_hist[HIST_LEN-2:0], r_a_sync[i]};
        assign w_b_hist = {r_b_hist[HIST_LEN-2:0], r_b_sync[i]};

        // Debounced bits follow the history only once it is unanimous.
        always_ff @(posedge clk12MHz or posedge reset) begin
            if (reset) begin
                r_a_hist <= '0;
                r_b_hist <= '0;
                r_a_db   <= 1'b0;
                r_b_db   <= 1'b0;
            end else if (w_tick) begin
                r_a_hist <= w_a_hist;
                r_b_hist <= w_b_hist;
                if (&w_a_hist) begin
                    r_a_db <= 1'b1;
                end else if (~|w_a_hist) begin
                    r_a_db <= 1'b0;
                end
                if (&w_b_hist) begin
                    r_b_db <= 1'b1;
                end else if (~|w_b_hist) begin
                    r_b_db <= 1'b0;
                end
            end
        end

        assign w_rise  = r_a_db && !r_a_prev;
        assign w_up_ok = LP_WRAP || (r_level != {WIDTH{1'b1}});
        assign w_dn_ok = LP_WRAP || (r_level != {WIDTH{1'b0}});

        // x1 decode: B low on the A rise counts up, B high counts down.
        always_ff @(posedge clk12MHz or posedge reset) begin
            if (reset) begin
                r_a_prev <= 1'b0;
                r_level  <= '0;
            end else if (w_tick) begin
                r_a_prev <= r_a_db;
                if (w_rise) begin
                    if (!r_b_db) begin
                        if (w_up_ok) begin
                            r_level <= r_level + 1'b1;
                        end
                    end else begin
                        if (w_dn_ok) begin
                            r_level <= r_level - 1'b1;
                        end
                    end
                end
            end
        end

        // Duty is only sampled at period start so a period never glitches.
        assign w_duty_nxt = w_wrap ? r_level : r_duty;

        always_ff @(posedge clk12MHz or posedge reset) begin
            if (reset) begin
                r_duty <= '0;
                r_pwm  <= 1'b0;
            end else if (w_tick) begin
                r_duty <= w_duty_nxt;
                r_pwm  <= (w_cnt_nxt < w_duty_nxt);
            end
        end

        assign level_out[i*WIDTH +: WIDTH] = r_level;
        assign pwm_out[i]                  = r_pwm;
    end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// tb_rgb_mixer_n: randomized self-checking bench for rgb_mixer_n.
// Drives saturating and wrapping instances from the same encoder inputs.
module tb_rgb_mixer_n;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int DB  = 2;
    localparam int HL  = 4;
    localparam int TPP = 1 << W;
    localparam int TOP = TPP - 1;
    localparam int TK  = 1 << DB;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     enc_a = '0;
    logic [CH-1:0]     enc_b = '0;
    logic [CH-1:0]     pwm_s;
    logic [CH-1:0]     pwm_w;
    logic [CH*W-1:0]   lvl_s;
    logic [CH*W-1:0]   lvl_w;

    int n_tests = 0;
    int n_fail  = 0;
    int m_sat  [CH];
    int m_wrap [CH];
    int cyc;
    int ticks;
    bit tick_flag;

    rgb_mixer_n #(
        .CHANNELS(CH), .WIDTH(W), .DIV_BITS(DB),
        .HIST_LEN(HL), .SATURATE(1)
    ) u_sat (
        .clk12MHz (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .pwm_out  (pwm_s),
        .level_out(lvl_s)
    );

    rgb_mixer_n #(
        .CHANNELS(CH), .WIDTH(W), .DIV_BITS(DB),
        .HIST_LEN(HL), .SATURATE(0)
    ) u_wrap (
        .clk12MHz (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .pwm_out  (pwm_w),
        .level_out(lvl_w)
    );

    always #5 clk = ~clk;

    // Tick timeline: tick on every TK-th clock edge after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc       <= 0;
            ticks     <= 0;
            tick_flag <= 1'b0;
        end else begin
            tick_flag <= ((cyc % TK) == TK - 1);
            if ((cyc % TK) == TK - 1) ticks <= ticks + 1;
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step_sat(input int l, input bit dn);
        if (dn) return (l > 0) ? l - 1 : 0;
        return (l < TOP) ? l + 1 : TOP;
    endfunction

    function automatic int step_wrap(input int l, input bit dn);
        return (l + (dn ? TOP : 1)) % TPP;
    endfunction

    task automatic check_levels(input string tag);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s_sat%0d", tag, i), lvl_s[i*W +: W], m_sat[i]);
            check($sformatf("%s_wrap%0d", tag, i), lvl_w[i*W +: W], m_wrap[i]);
        end
    endtask

    task automatic do_step(input logic [CH-1:0] mask,
                           input logic [CH-1:0] dn, input string tag);
        enc_b = dn;
        enc_a = mask;
        repeat (32) @(negedge clk);
        enc_a = '0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            if (mask[i]) begin
                m_sat[i]  = step_sat(m_sat[i], dn[i]);
                m_wrap[i] = step_wrap(m_wrap[i], dn[i]);
            end
        end
        check_levels(tag);
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick_flag && k < 4 * TK);
        if (!tick_flag) check("tick_timeout", tick_flag, 1);
    endtask

    task automatic wait_period_start();
        int k = 0;
        do begin
            wait_tick();
            k++;
        end while ((ticks % TPP) != 0 && k < 2 * TPP);
        if ((ticks % TPP) != 0) check("period_timeout", ticks % TPP, 0);
    endtask

    // Counts high samples over one period, starting at the current tick.
    task automatic measure(input int exp_s[CH], input string tag);
        int cnt [CH];
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        for (int t = 0; t < TPP; t++) begin
            if (t > 0) wait_tick();
            for (int i = 0; i < CH; i++) cnt[i] += int'(pwm_s[i]);
        end
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s_duty%0d", tag, i), cnt[i], exp_s[i]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap [CH];
        logic [CH-1:0] mk;
        logic [CH-1:0] dr;

        for (int i = 0; i < CH; i++) begin
            m_sat[i]  = 0;
            m_wrap[i] = 0;
        end

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            enc_a = CH'($urandom);
            enc_b = CH'($urandom);
            if (k % 5 == 4) begin
                check("rst_pwm_s", pwm_s, 0);
                check("rst_lvl_s", lvl_s, 0);
                check("rst_lvl_w", lvl_w, 0);
            end
        end
        enc_a = '0;
        enc_b = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            repeat (10) @(negedge clk);
            check("idle_pwm_s", pwm_s, 0);
            check("idle_pwm_w", pwm_w, 0);
            check("idle_lvl_s", lvl_s, 0);
        end

        do_step(3'b010, 3'b010, "dn_at_0");
        do_step(3'b010, 3'b000, "up_from_wrap");

        for (int k = 0; k < 5; k++) do_step(3'b001, 3'b000, "up5");
        for (int k = 0; k < 2; k++) do_step(3'b001, 3'b001, "dn2");
        check("dir_level", lvl_s[0 +: W], 3);
        wait_period_start();
        snap = m_sat;
        measure(snap, "pwm3");

        enc_b = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            enc_a[2] = ~enc_a[2];
        end
        enc_a[2] = 1'b1;
        repeat (40) @(negedge clk);
        enc_a = '0;
        repeat (32) @(negedge clk);
        m_sat[2]  = step_sat(m_sat[2], 1'b0);
        m_wrap[2] = step_wrap(m_wrap[2], 1'b0);
        check_levels("bounce");

        for (int k = 0; k < 20; k++) begin
            mk = CH'($urandom_range(1, 7));
            dr = CH'($urandom);
            do_step(mk, dr, "rand");
        end

        for (int k = 0; k < 3; k++) do_step(3'b001, 3'b000, "pre_glitch");
        wait_period_start();
        snap = m_sat;
        fork
            measure(snap, "glitch_cur");
            begin
                do_step(3'b010, CH'($urandom), "ch1_only");
                do_step(3'b011, 3'b000, "ch01");
                do_step(3'b001, 3'b000, "ch0");
            end
        join
        wait_tick();
        snap = m_sat;
        measure(snap, "glitch_next");

        for (int k = 0; k < 260; k++) do_step(3'b111, 3'b000, "sat_up");
        wait_period_start();
        snap = m_sat;
        measure(snap, "pwm_max");
        do_step(3'b111, 3'b111, "sat_dn");
        wait_period_start();
        snap = m_sat;
        measure(snap, "pwm_254");

        wait_tick();
        check("pre_rst_pwm", pwm_s, 3'b111);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_pwm_s", pwm_s, 0);
        check("async_pwm_w", pwm_w, 0);
        check("async_lvl_s", lvl_s, 0);
        check("async_lvl_w", lvl_w, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
